// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: controller state, NOP encoding, bubble word.
// Imported by the pipeline controller and its hazard unit.
package rv32i_types;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ctrl_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
    } rv32i_control_word_t;

    localparam rv32i_control_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection between id_ex (producer) and if_id (consumer).
// Purely combinational; x0 never creates a dependency.
module hazard_detect
    import rv32i_types::*;
(
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       lu
);

    logic rd_nz;
    logic rs_hit;

    // Compare the load destination against both source operands
    always_comb begin
        rd_nz  = (ex_rd != 5'd0);
        rs_hit = (ex_rd == id_rs1) | (ex_rd == id_rs2);
        lu     = ex_is_load & rd_nz & rs_hit;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Optional counters: define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             br_taken,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt,
`endif
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             imem_mask,
    output logic             dmem_mask,
    output logic             stalled
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        imem_done_q;
    logic        dmem_done_q;
    logic        i_ok;
    logic        d_ok;
    logic        advance;
    logic        lu;

    hazard_detect u_hazard (
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .lu         (lu)
    );

    // A side is satisfied if idle, answering now, or already answered
    always_comb begin
        i_ok    = ~imem_read | imem_resp | imem_done_q;
        d_ok    = ~dmem_req | dmem_resp | dmem_done_q;
        advance = i_ok & d_ok;
    end

    // Enables, flushes and next state; memory wait beats branch beats bubble
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        state_d     = state_q;
        if (!rst) begin
            unique case (1'b1)
                ~advance: begin
                    state_d = STALL;
                end
                advance & br_taken: begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = RUN;
                end
                advance & ~br_taken & lu: begin
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = RUN;
                end
                default: begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    state_d     = RUN;
                end
            endcase
        end
    end

    // Status outputs follow the registered state and done latches
    always_comb begin
        stalled   = (state_q == STALL);
        imem_mask = imem_done_q;
        dmem_mask = dmem_done_q;
    end

    // State register and done latches; a response that lands on the
    // advancing cycle is consumed there and never latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                imem_done_q <= 1'b0;
                dmem_done_q <= 1'b0;
            end else begin
                imem_done_q <= imem_done_q | imem_resp;
                dmem_done_q <= dmem_done_q | dmem_resp;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic lu_bubble;

    // A load-use bubble is an id_ex flush without an if_id flush
    always_comb begin
        lu_bubble = flush_id_ex & ~flush_if_id;
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (~advance && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_if_id && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_ONE;
            if (lu_bubble && lu_cnt != CNT_MAX)
                lu_cnt <= lu_cnt + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed output vectors.
// Output vector: {ld_pc,ld_ifid,ld_idex,ld_exmem,ld_memwb,fl_ifid,fl_idex,imask,dmask,stalled}
module tb_pipeline_ctrl;

    localparam logic [9:0] V_IDLE   = 10'b00000_00_000;
    localparam logic [9:0] V_ALL    = 10'b11111_00_000;
    localparam logic [9:0] V_LU     = 10'b00111_01_000;
    localparam logic [9:0] V_BR     = 10'b11111_11_000;
    localparam logic [9:0] V_STL    = 10'b00000_00_001;
    localparam logic [9:0] V_ADV_S  = 10'b11111_00_001;
    localparam logic [9:0] V_DM_STL = 10'b00000_00_011;
    localparam logic [9:0] V_DM_ADV = 10'b11111_00_011;
    localparam logic [9:0] V_IM_STL = 10'b00000_00_101;

    logic       clk;
    logic       rst;
    logic       imem_read;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       br_taken;
    logic       load_pc;
    logic       load_if_id;
    logic       load_id_ex;
    logic       load_ex_mem;
    logic       load_mem_wb;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       imem_mask;
    logic       dmem_mask;
    logic       stalled;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] lu_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_read   (imem_read),
        .imem_resp   (imem_resp),
        .dmem_req    (dmem_req),
        .dmem_resp   (dmem_resp),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .br_taken    (br_taken),
`ifdef PIPELINE_CTRL_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .lu_cnt      (lu_cnt),
`endif
        .load_pc     (load_pc),
        .load_if_id  (load_if_id),
        .load_id_ex  (load_id_ex),
        .load_ex_mem (load_ex_mem),
        .load_mem_wb (load_mem_wb),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .imem_mask   (imem_mask),
        .dmem_mask   (dmem_mask),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] outs;
    assign outs = {load_pc, load_if_id, load_id_ex, load_ex_mem,
                   load_mem_wb, flush_if_id, flush_id_ex,
                   imem_mask, dmem_mask, stalled};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check outputs at the falling edge, then step past the next rising edge
    task automatic cyc(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, {22'd0, outs}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic ir, input logic irs,
                       input logic dr, input logic drs);
        imem_read = ir;
        imem_resp = irs;
        dmem_req  = dr;
        dmem_resp = drs;
    endtask

    task automatic hz(input logic ld, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2);
        ex_is_load = ld;
        ex_rd      = rd;
        id_rs1     = r1;
        id_rs2     = r2;
    endtask

    initial begin
        rst      = 1'b1;
        br_taken = 1'b1;
        mem(1'b0, 1'b0, 1'b0, 1'b0);
        hz(1'b0, 5'd0, 5'd0, 5'd0);
        cyc("reset0", V_IDLE);
        cyc("reset1", V_IDLE);
`ifdef PIPELINE_CTRL_PERF_EN
        check("rst_cnt_stall", stall_cnt, 32'd0);
`endif
        rst      = 1'b0;
        br_taken = 1'b0;

        mem(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("run%0d", i), V_ALL);

        hz(1'b1, 5'd5, 5'd5, 5'd0);
        cyc("lu_rs1", V_LU);
        hz(1'b1, 5'd7, 5'd1, 5'd7);
        cyc("lu_rs2", V_LU);
        hz(1'b1, 5'd0, 5'd0, 5'd0);
        cyc("lu_x0", V_ALL);
        hz(1'b0, 5'd5, 5'd5, 5'd5);
        cyc("no_load", V_ALL);

        hz(1'b0, 5'd0, 5'd0, 5'd0);
        mem(1'b1, 1'b0, 1'b0, 1'b0);
        cyc("istl_c0", V_IDLE);
        cyc("istl_c1", V_STL);
        cyc("istl_c2", V_STL);
        mem(1'b1, 1'b1, 1'b0, 1'b0);
        cyc("istl_c3", V_ADV_S);
        cyc("istl_c4", V_ALL);

        mem(1'b1, 1'b0, 1'b1, 1'b0);
        cyc("dm_c0", V_IDLE);
        mem(1'b1, 1'b0, 1'b1, 1'b1);
        cyc("dm_c1", V_STL);
        mem(1'b1, 1'b0, 1'b1, 1'b0);
        cyc("dm_c2", V_DM_STL);
        cyc("dm_c3", V_DM_STL);
        mem(1'b1, 1'b1, 1'b1, 1'b0);
        cyc("dm_c4", V_DM_ADV);
        mem(1'b1, 1'b1, 1'b0, 1'b0);
        cyc("dm_c5", V_ALL);

        hz(1'b1, 5'd3, 5'd3, 5'd3);
        br_taken = 1'b1;
        cyc("br_lu", V_BR);
        br_taken = 1'b0;
        hz(1'b0, 5'd0, 5'd0, 5'd0);
        cyc("after_br", V_ALL);

        mem(1'b1, 1'b1, 1'b1, 1'b0);
        cyc("im_done_set", V_IDLE);
        mem(1'b1, 1'b0, 1'b1, 1'b0);
        cyc("im_mask_on", V_IM_STL);
        rst = 1'b1;
        cyc("rst_mid", V_IDLE);
`ifdef PIPELINE_CTRL_PERF_EN
        check("rst_cnt_stall2", stall_cnt, 32'd0);
        check("rst_cnt_flush", flush_cnt, 32'd0);
        check("rst_cnt_lu", lu_cnt, 32'd0);
`endif
        rst = 1'b0;
        mem(1'b1, 1'b0, 1'b0, 1'b0);
        cyc("post_rst", V_IDLE);
        cyc("post_rst_stl", V_STL);
`ifdef PIPELINE_CTRL_PERF_EN
        check("cnt_stall_inc", stall_cnt, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
